// File: rtl/cci_rd_arb_pkg.sv
// Shared types and Mdata pack/unpack helpers for the CCI-P c0 read arbiter.
// Helpers take field widths as arguments so parameterised instances can reuse them.
package cci_rd_arb_pkg;

    localparam int CID_BITS_DEF  = 2;
    localparam int TAG_BITS_DEF  = 8;
    localparam int ADDR_BITS_DEF = 42;
    localparam int MDATA_MAX     = 64;

    typedef logic [CID_BITS_DEF-1:0]  t_cid;
    typedef logic [TAG_BITS_DEF-1:0]  t_tag;
    typedef logic [ADDR_BITS_DEF-1:0] t_line_addr;

    function automatic logic [MDATA_MAX-1:0] mdata_pack(input logic [7:0] cid,
                                                        input logic [MDATA_MAX-1:0] tag,
                                                        input int tag_bits);
        logic [MDATA_MAX-1:0] tmask;
        tmask = (MDATA_MAX'(1) << tag_bits) - MDATA_MAX'(1);
        return (tag & tmask) | (MDATA_MAX'(cid) << tag_bits);
    endfunction

    function automatic logic [7:0] mdata_cid(input logic [MDATA_MAX-1:0] mdata,
                                             input int tag_bits, input int cid_bits);
        logic [MDATA_MAX-1:0] cmask;
        cmask = (MDATA_MAX'(1) << cid_bits) - MDATA_MAX'(1);
        return 8'((mdata >> tag_bits) & cmask);
    endfunction

    function automatic logic [MDATA_MAX-1:0] mdata_tag(input logic [MDATA_MAX-1:0] mdata,
                                                       input int tag_bits);
        logic [MDATA_MAX-1:0] tmask;
        tmask = (MDATA_MAX'(1) << tag_bits) - MDATA_MAX'(1);
        return mdata & tmask;
    endfunction

endpackage

// File: rtl/cci_rd_req_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves to just past the winner, and holds when idle.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            idx;

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_d    = PW'((idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
endmodule

// File: rtl/cci_rd_req_arbiter.sv
// Shares CCI-P c0 reads among NUM_CLIENTS requesters: round-robin grant with
// almost-full and per-client outstanding throttling, cid-in-Mdata response routing.
module cci_rd_req_arbiter
    import cci_rd_arb_pkg::*;
#(
    parameter int NUM_CLIENTS     = 4,
    parameter int CID_BITS        = $clog2(NUM_CLIENTS),
    parameter int TAG_BITS        = 8,
    parameter int MAX_OUTSTANDING = 64,
    parameter int ADDR_BITS       = 42,
    parameter int DATA_BITS       = 512,
    parameter int MDATA_BITS      = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CLIENTS-1:0]          cl_req_valid,
    input  logic [NUM_CLIENTS*ADDR_BITS-1:0] cl_req_addr,
    input  logic [NUM_CLIENTS*TAG_BITS-1:0] cl_req_tag,
    output logic [NUM_CLIENTS-1:0]          cl_req_ready,
    output logic                            c0_tx_valid,
    output logic [ADDR_BITS-1:0]            c0_tx_addr,
    output logic [MDATA_BITS-1:0]           c0_tx_mdata,
    input  logic                            c0_tx_almfull,
    input  logic                            c0_rx_rdvalid,
    input  logic [MDATA_BITS-1:0]           c0_rx_mdata,
    input  logic [DATA_BITS-1:0]            c0_rx_data,
    output logic [NUM_CLIENTS-1:0]          cl_rsp_valid,
    output logic [TAG_BITS-1:0]             cl_rsp_tag,
    output logic [DATA_BITS-1:0]            cl_rsp_data,
    output logic [15:0]                     in_flight,
    output logic                            idle,
    output logic                            err_sticky
);
    if (CID_BITS + TAG_BITS > MDATA_BITS) begin : g_bad_mdata
        $error("cci_rd_req_arbiter: CID_BITS+TAG_BITS exceeds MDATA_BITS");
    end

    logic [NUM_CLIENTS-1:0] elig, gnt, dec;
    logic [ADDR_BITS-1:0]   addr_sel;
    logic [TAG_BITS-1:0]    tag_sel, rx_tag;
    logic [CID_BITS-1:0]    cid_sel, rx_cid;

    logic                   tx_valid_q, tx_valid_d;
    logic [ADDR_BITS-1:0]   tx_addr_q, tx_addr_d;
    logic [MDATA_BITS-1:0]  tx_mdata_q, tx_mdata_d;
    logic [NUM_CLIENTS-1:0] rsp_valid_q, rsp_valid_d;
    logic [TAG_BITS-1:0]    rsp_tag_q, rsp_tag_d;
    logic [DATA_BITS-1:0]   rsp_data_q, rsp_data_d;
    logic [7:0]             cnt_q [NUM_CLIENTS];
    logic [7:0]             cnt_d [NUM_CLIENTS];
    logic [15:0]            in_flight_q, in_flight_d;
    logic                   err_q, err_d;

    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++)
            elig[i] = cl_req_valid[i] && (cnt_q[i] < 8'(MAX_OUTSTANDING)) && !c0_tx_almfull;
    end

    rr_arbiter #(.N(NUM_CLIENTS)) u_rr (
        .clk   (clk),
        .reset (reset),
        .req   (elig),
        .gnt   (gnt)
    );

    assign rx_cid = CID_BITS'(mdata_cid(MDATA_MAX'(c0_rx_mdata), TAG_BITS, CID_BITS));
    assign rx_tag = TAG_BITS'(mdata_tag(MDATA_MAX'(c0_rx_mdata), TAG_BITS));

    always_comb begin
        addr_sel    = '0;
        tag_sel     = '0;
        cid_sel     = '0;
        in_flight_d = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (gnt[i]) begin
                addr_sel = cl_req_addr[i*ADDR_BITS +: ADDR_BITS];
                tag_sel  = cl_req_tag[i*TAG_BITS +: TAG_BITS];
                cid_sel  = CID_BITS'(i);
            end
            // A response may pair with an accept in the same cycle even at cnt==0.
            dec[i]      = c0_rx_rdvalid && (rx_cid == CID_BITS'(i)) && ((cnt_q[i] != 8'd0) || gnt[i]);
            cnt_d[i]    = cnt_q[i] + 8'(gnt[i]) - 8'(dec[i]);
            in_flight_d = in_flight_d + 16'(cnt_d[i]);
        end

        tx_valid_d = |gnt;
        tx_addr_d  = tx_valid_d ? addr_sel : tx_addr_q;
        tx_mdata_d = tx_valid_d ? MDATA_BITS'(mdata_pack(8'(cid_sel), MDATA_MAX'(tag_sel), TAG_BITS))
                                : tx_mdata_q;

        rsp_valid_d = dec;
        rsp_tag_d   = (|dec) ? rx_tag     : rsp_tag_q;
        rsp_data_d  = (|dec) ? c0_rx_data : rsp_data_q;
        err_d       = err_q || (c0_rx_rdvalid && !(|dec));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_valid_q  <= 1'b0;
            tx_addr_q   <= '0;
            tx_mdata_q  <= '0;
            rsp_valid_q <= '0;
            rsp_tag_q   <= '0;
            rsp_data_q  <= '0;
            in_flight_q <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_CLIENTS; i++) cnt_q[i] <= '0;
        end else begin
            tx_valid_q  <= tx_valid_d;
            tx_addr_q   <= tx_addr_d;
            tx_mdata_q  <= tx_mdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_data_q  <= rsp_data_d;
            in_flight_q <= in_flight_d;
            err_q       <= err_d;
            for (int i = 0; i < NUM_CLIENTS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign cl_req_ready = gnt;
    assign c0_tx_valid  = tx_valid_q;
    assign c0_tx_addr   = tx_addr_q;
    assign c0_tx_mdata  = tx_mdata_q;
    assign cl_rsp_valid = rsp_valid_q;
    assign cl_rsp_tag   = rsp_tag_q;
    assign cl_rsp_data  = rsp_data_q;
    assign in_flight    = in_flight_q;
    assign idle         = (in_flight_q == 16'd0) && !tx_valid_q;
    assign err_sticky   = err_q;
endmodule

// File: tb/tb_cci_rd_req_arbiter.sv
// Bench for cci_rd_req_arbiter: directed scenarios plus randomized traffic, all
// checked against a transaction-level reference model kept in the bench.
module tb_cci_rd_req_arbiter;
    localparam int N    = 4;
    localparam int TB   = 8;
    localparam int AB   = 42;
    localparam int DB   = 512;
    localparam int MB   = 16;
    localparam int MAXO = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    cl_req_valid;
    logic [N*AB-1:0] cl_req_addr;
    logic [N*TB-1:0] cl_req_tag;
    logic [N-1:0]    cl_req_ready;
    logic            c0_tx_valid;
    logic [AB-1:0]   c0_tx_addr;
    logic [MB-1:0]   c0_tx_mdata;
    logic            c0_tx_almfull;
    logic            c0_rx_rdvalid;
    logic [MB-1:0]   c0_rx_mdata;
    logic [DB-1:0]   c0_rx_data;
    logic [N-1:0]    cl_rsp_valid;
    logic [TB-1:0]   cl_rsp_tag;
    logic [DB-1:0]   cl_rsp_data;
    logic [15:0]     in_flight;
    logic            idle;
    logic            err_sticky;

    cci_rd_req_arbiter #(.NUM_CLIENTS(N), .TAG_BITS(TB), .MAX_OUTSTANDING(MAXO),
                         .ADDR_BITS(AB), .DATA_BITS(DB), .MDATA_BITS(MB)) dut (
        .clk(clk), .reset(reset),
        .cl_req_valid(cl_req_valid), .cl_req_addr(cl_req_addr), .cl_req_tag(cl_req_tag),
        .cl_req_ready(cl_req_ready),
        .c0_tx_valid(c0_tx_valid), .c0_tx_addr(c0_tx_addr), .c0_tx_mdata(c0_tx_mdata),
        .c0_tx_almfull(c0_tx_almfull),
        .c0_rx_rdvalid(c0_rx_rdvalid), .c0_rx_mdata(c0_rx_mdata), .c0_rx_data(c0_rx_data),
        .cl_rsp_valid(cl_rsp_valid), .cl_rsp_tag(cl_rsp_tag), .cl_rsp_data(cl_rsp_data),
        .in_flight(in_flight), .idle(idle), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state (transaction level)
    typedef struct { int cid; logic [TB-1:0] tag; } t_out;
    t_out          outq[$];
    t_out          stale[$];
    int            m_ptr;
    int            m_cnt [N];
    bit            m_err;
    bit            e_tx_valid;
    logic [AB-1:0] e_tx_addr;
    logic [MB-1:0] e_tx_mdata;
    logic [N-1:0]  e_rsp_valid;
    logic [TB-1:0] e_rsp_tag;
    logic [DB-1:0] e_rsp_data;
    logic [AB-1:0] addr_a [N];
    logic [TB-1:0] tag_a [N];
    logic [N-1:0]  last_ready;

    function automatic int model_sum();
        int s = 0;
        foreach (m_cnt[i]) s += m_cnt[i];
        return s;
    endfunction

    function automatic logic [MB-1:0] mk_md(input int cid, input logic [TB-1:0] tag);
        return MB'(cid * 256) | MB'(tag);
    endfunction

    function automatic logic [DB-1:0] rnd_data();
        logic [DB-1:0] d;
        for (int i = 0; i < DB/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        cl_req_valid = '0; c0_tx_almfull = 1'b0; c0_rx_rdvalid = 1'b0;
        c0_rx_mdata = '0; c0_rx_data = '0;
        @(posedge clk); @(posedge clk); #1;
        foreach (outq[i]) stale.push_back(outq[i]);
        outq.delete();
        m_ptr = 0; m_err = 0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        e_tx_valid = 0; e_tx_addr = '0; e_tx_mdata = '0;
        e_rsp_valid = '0; e_rsp_tag = '0; e_rsp_data = '0;
        check_eq("rst_tx_valid", DB'(c0_tx_valid), '0);
        check_eq("rst_rsp_valid", DB'(cl_rsp_valid), '0);
        check_eq("rst_in_flight", DB'(in_flight), '0);
        check_eq("rst_idle", DB'(idle), DB'(1));
        check_eq("rst_err", DB'(err_sticky), '0);
        check_eq("rst_ready", DB'(cl_req_ready), '0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock: drive at negedge, check grant, apply the model at posedge, check outputs.
    task automatic step(input logic [N-1:0] v, input bit af, input bit rdv,
                        input logic [MB-1:0] rmd, input logic [DB-1:0] rdat);
        int g, rc, idx;
        bit matched;
        for (int i = 0; i < N; i++) begin
            cl_req_addr[i*AB +: AB] = addr_a[i];
            cl_req_tag[i*TB +: TB]  = tag_a[i];
        end
        cl_req_valid = v; c0_tx_almfull = af;
        c0_rx_rdvalid = rdv; c0_rx_mdata = rmd; c0_rx_data = rdat;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && v[idx] && m_cnt[idx] < MAXO && !af) g = idx;
        end
        last_ready = cl_req_ready;
        check_eq("ready", DB'(cl_req_ready), (g >= 0) ? DB'(1) << g : '0);
        rc = int'(rmd[TB +: 2]);
        matched = rdv && rc < N && (m_cnt[rc] > 0 || g == rc);
        @(posedge clk);
        e_tx_valid = (g >= 0);
        if (g >= 0) begin
            m_cnt[g]++;
            m_ptr = (g + 1) % N;
            e_tx_addr = addr_a[g];
            e_tx_mdata = mk_md(g, tag_a[g]);
            outq.push_back('{g, tag_a[g]});
        end
        e_rsp_valid = '0;
        if (matched) begin
            m_cnt[rc]--;
            e_rsp_valid = N'(1) << rc;
            e_rsp_tag = rmd[TB-1:0];
            e_rsp_data = rdat;
            foreach (outq[i])
                if (outq[i].cid == rc && outq[i].tag == rmd[TB-1:0]) begin
                    outq.delete(i);
                    break;
                end
        end else if (rdv) m_err = 1;
        #1;
        check_eq("tx_valid", DB'(c0_tx_valid), DB'(e_tx_valid));
        if (e_tx_valid) begin
            check_eq("tx_addr", DB'(c0_tx_addr), DB'(e_tx_addr));
            check_eq("tx_mdata", DB'(c0_tx_mdata), DB'(e_tx_mdata));
        end
        check_eq("rsp_valid", DB'(cl_rsp_valid), DB'(e_rsp_valid));
        check_eq("rsp_tag", DB'(cl_rsp_tag), DB'(e_rsp_tag));
        check_eq("rsp_data", cl_rsp_data, e_rsp_data);
        check_eq("in_flight", DB'(in_flight), DB'(model_sum()));
        check_eq("idle", DB'(idle), DB'(model_sum() == 0 && !e_tx_valid));
        check_eq("err", DB'(err_sticky), DB'(m_err));
        @(negedge clk);
    endtask

    task automatic idle_step();
        step('0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        int txc, acc;
        t_out r;
        reset = 1'b1;
        cl_req_addr = '0; cl_req_tag = '0;
        for (int i = 0; i < N; i++) begin addr_a[i] = AB'(i * 64); tag_a[i] = TB'(i); end
        @(negedge clk);
        do_reset();

        // Single request from client 1
        addr_a[1] = AB'('h100); tag_a[1] = 8'h5A;
        step(4'b0010, 0, 0, '0, '0);
        check_eq("t1_ready", DB'(last_ready), DB'(4'b0010));
        check_eq("t1_mdata", DB'(c0_tx_mdata), DB'(16'h015A));
        check_eq("t1_addr", DB'(c0_tx_addr), DB'('h100));
        check_eq("t1_in_flight", DB'(in_flight), DB'(1));

        // All clients request: strict rotation from pointer 0
        do_reset();
        for (int c = 0; c < 8; c++) begin
            step(4'hF, 0, 0, '0, '0);
            check_eq("rr_seq", DB'(last_ready), DB'(1) << (c % N));
        end

        // Almost-full throttling: only an already-registered request may issue
        do_reset();
        step(4'hF, 0, 0, '0, '0);
        txc = 0;
        for (int c = 0; c < 5; c++) begin
            step(4'hF, 1, 0, '0, '0);
            if (c0_tx_valid) txc++;
            check_eq("af_ready", DB'(last_ready), '0);
        end
        check_eq("af_tx_count", DB'(txc), '0);
        step(4'hF, 0, 0, '0, '0);
        check_eq("af_resume", DB'(last_ready), DB'(4'b0010));

        // Outstanding limit on client 0, then a response frees a slot
        do_reset();
        acc = 0;
        for (int c = 0; c < MAXO + 3; c++) begin
            tag_a[0] = TB'(c + 7);
            step(4'b0001, 0, 0, '0, '0);
            if (last_ready[0]) acc++;
        end
        check_eq("lim_accepts", DB'(acc), DB'(MAXO));
        step(4'b0001, 0, 1, 16'h0007, rnd_data());
        check_eq("lim_rsp_valid", DB'(cl_rsp_valid), DB'(4'b0001));
        check_eq("lim_rsp_tag", DB'(cl_rsp_tag), DB'(8'h07));
        step(4'b0001, 0, 0, '0, '0);
        check_eq("lim_reaccept", DB'(last_ready), DB'(4'b0001));

        // Same-cycle accept and response on client 2 at count 3
        do_reset();
        for (int c = 0; c < 3; c++) step(4'b0100, 0, 0, '0, '0);
        step(4'b0100, 0, 1, mk_md(2, tag_a[2]), rnd_data());
        check_eq("sim_in_flight", DB'(in_flight), DB'(3));
        check_eq("sim_rsp_valid", DB'(cl_rsp_valid), DB'(4'b0100));

        // Unmatched response, then reset with reads in flight and late responses
        do_reset();
        step('0, 0, 1, mk_md(3, 8'h33), rnd_data());
        check_eq("um_err", DB'(err_sticky), DB'(1));
        check_eq("um_rsp_valid", DB'(cl_rsp_valid), '0);
        for (int c = 0; c < 5; c++) step(4'hF, 0, 0, '0, '0);
        idle_step();
        check_eq("pre_rst_in_flight", DB'(in_flight), DB'(5));
        stale.delete();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            r = stale.pop_front();
            step('0, 0, 1, mk_md(r.cid, r.tag), rnd_data());
            check_eq("late_rsp_valid", DB'(cl_rsp_valid), '0);
        end
        check_eq("late_err", DB'(err_sticky), DB'(1));

        // Randomized traffic with out-of-order responses and occasional resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0]  v;
            bit            af, rdv;
            logic [MB-1:0] rmd;
            int            pick;
            for (int i = 0; i < N; i++) begin
                addr_a[i] = {$urandom, $urandom};
                tag_a[i]  = TB'($urandom);
            end
            v = N'($urandom_range(0, 15));
            af = ($urandom_range(0, 9) == 0);
            rdv = 0; rmd = '0;
            if (outq.size() > 0 && $urandom_range(0, 9) < 5) begin
                pick = $urandom_range(0, outq.size() - 1);
                rdv = 1; rmd = mk_md(outq[pick].cid, outq[pick].tag);
            end else if ($urandom_range(0, 39) == 0) begin
                rdv = 1; rmd = MB'($urandom);
            end
            step(v, af, rdv, rmd, rnd_data());
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
